// File: rtl/p405s_dvc_pkg.sv
// Shared encodings for the load/store data-value-compare unit.
// Holds the match modes, the per-comparator arm state and the mode reduction.
package p405s_dvc_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_EQ_ANY = 2'b01,
        MODE_EQ_ALL = 2'b10,
        MODE_NE_ANY = 2'b11
    } dvc_mode_e;

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        FIRED    = 2'b10
    } dvc_state_e;

    // Reduce per-lane results to a single hit according to the match mode
    function automatic logic dvc_mode_hit(
        input dvc_mode_e mode,
        input logic      any_eq,
        input logic      all_en_eq,
        input logic      any_en,
        input logic      any_ne
    );
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_EQ_ANY: hit = any_eq;
            MODE_EQ_ALL: hit = any_en & all_en_eq;
            MODE_NE_ANY: hit = any_ne;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/p405s_dvc_chan.sv
// One data-value comparator: config registers, lane compare, sticky status,
// saturating hit counter and the arm/threshold state machine (stage2).
module p405s_dvc_chan
    import p405s_dvc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_wr,
    input  logic [DATA_W-1:0]   cfg_value,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_thresh,
    input  logic                arm,
    input  logic                clr_sticky,
    input  logic                s1_valid,
    input  logic [DATA_W-1:0]   s1_data,
    input  logic [DATA_W/8-1:0] s1_be,
    output logic [DATA_W/8-1:0] byte_cmp,
    output logic                hit,
    output logic                sticky,
    output logic                evt,
    output logic [CNT_W-1:0]    count
);

    localparam int unsigned BYTES = DATA_W / 8;

    logic [DATA_W-1:0] value_q,  value_d;
    dvc_mode_e         mode_q,   mode_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    dvc_state_e        state_q,  state_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [BYTES-1:0]  cmp_q,    cmp_d;
    logic              hit_q,    hit_d;
    logic              sticky_q, sticky_d;
    logic              evt_q,    evt_d;

    logic [BYTES-1:0]  lane_eq_c;
    logic              hit_c;
    logic [CNT_W-1:0]  thr_eff_c;
    logic [CNT_W-1:0]  count_inc_c;

    // Lane compare against the stored value, qualified by the match mode
    always_comb begin
        lane_eq_c = '0;
        for (int unsigned k = 0; k < BYTES; k++) begin
            lane_eq_c[k] = s1_be[k] & (s1_data[8*k +: 8] == value_q[8*k +: 8]);
        end
        hit_c = s1_valid & dvc_mode_hit(mode_q, |lane_eq_c, lane_eq_c == s1_be,
                                        |s1_be, |(s1_be & ~lane_eq_c));
    end

    always_comb begin
        value_d  = value_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        cmp_d    = s1_valid ? lane_eq_c : '0;
        hit_d    = hit_c;
        sticky_d = hit_c | (sticky_q & ~clr_sticky);
        if (cfg_wr) begin
            value_d  = cfg_value;
            mode_d   = dvc_mode_e'(cfg_mode);
            thresh_d = cfg_thresh;
        end
    end

    // Arm/threshold FSM; a config write disarms and wins over a same-cycle arm
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        evt_d       = 1'b0;
        thr_eff_c   = (thresh_q == '0) ? CNT_W'(1) : thresh_q;
        count_inc_c = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        if (cfg_wr) begin
            if (state_q == ARMED) begin
                count_d = '0;
            end
            state_d = DISARMED;
        end else if (arm) begin
            state_d = ARMED;
            count_d = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (hit_c) begin
                        count_d = count_inc_c;
                        if (count_inc_c >= thr_eff_c) begin
                            state_d = FIRED;
                            evt_d   = 1'b1;
                        end
                    end
                end
                FIRED:   state_d = DISARMED;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q  <= '0;
            mode_q   <= MODE_OFF;
            thresh_q <= CNT_W'(1);
            state_q  <= DISARMED;
            count_q  <= '0;
            cmp_q    <= '0;
            hit_q    <= 1'b0;
            sticky_q <= 1'b0;
            evt_q    <= 1'b0;
        end else begin
            value_q  <= value_d;
            mode_q   <= mode_d;
            thresh_q <= thresh_d;
            state_q  <= state_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            hit_q    <= hit_d;
            sticky_q <= sticky_d;
            evt_q    <= evt_d;
        end
    end

    assign byte_cmp = cmp_q;
    assign hit      = hit_q;
    assign sticky   = sticky_q;
    assign evt      = evt_q;
    assign count    = count_q;

endmodule

// File: rtl/p405s_ld_st_dvc_unit.sv
// Data-value-compare debug unit on the LSU load/store data path.
// Registers the incoming beat (stage1) and fans it out to NUM_DVC comparators.
module p405s_ld_st_dvc_unit
    import p405s_dvc_pkg::*;
#(
    parameter int unsigned NUM_DVC = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned BYTES  = DATA_W / 8,
    localparam int unsigned SEL_W  = (NUM_DVC > 1) ? $clog2(NUM_DVC) : 1
) (
    input  logic                     CB,
    input  logic                     resetCore_N,
    input  logic                     cfgWrEn,
    input  logic [SEL_W-1:0]         cfgSel,
    input  logic [DATA_W-1:0]        cfgValue,
    input  logic [1:0]               cfgMode,
    input  logic [CNT_W-1:0]         cfgThresh,
    input  logic [NUM_DVC-1:0]       armEn,
    input  logic [NUM_DVC-1:0]       clrSticky,
    input  logic                     dataValid,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic [BYTES-1:0]         byteEn,
    output logic [NUM_DVC*BYTES-1:0] dvcByteCmp,
    output logic [NUM_DVC-1:0]       dvcHit,
    output logic [NUM_DVC-1:0]       dvcSticky,
    output logic [NUM_DVC-1:0]       dvcEvent,
    output logic [NUM_DVC*CNT_W-1:0] dvcCount
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [BYTES-1:0]  s1_be_q,    s1_be_d;

    always_comb begin
        s1_valid_d = dataValid;
        s1_data_d  = dataIn;
        s1_be_d    = byteEn;
    end

    always_ff @(posedge CB) begin
        if (!resetCore_N) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_be_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_be_q    <= s1_be_d;
        end
    end

    // Out-of-range selects match no comparator, so such writes are dropped
    for (genvar i = 0; i < NUM_DVC; i++) begin : g_chan
        logic wr_c;
        assign wr_c = cfgWrEn & (cfgSel == SEL_W'(i));

        p405s_dvc_chan #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk        (CB),
            .rst_n      (resetCore_N),
            .cfg_wr     (wr_c),
            .cfg_value  (cfgValue),
            .cfg_mode   (cfgMode),
            .cfg_thresh (cfgThresh),
            .arm        (armEn[i]),
            .clr_sticky (clrSticky[i]),
            .s1_valid   (s1_valid_q),
            .s1_data    (s1_data_q),
            .s1_be      (s1_be_q),
            .byte_cmp   (dvcByteCmp[i*BYTES +: BYTES]),
            .hit        (dvcHit[i]),
            .sticky     (dvcSticky[i]),
            .evt        (dvcEvent[i]),
            .count      (dvcCount[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_p405s_ld_st_dvc_unit.sv
// Self-checking bench for p405s_ld_st_dvc_unit: a cycle model pushes expected
// outputs to a scoreboard that is popped and compared after every clock edge.
module tb_p405s_ld_st_dvc_unit;

    localparam int NUM_DVC = 3;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 8;
    localparam int BYTES   = 4;
    localparam int SEL_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     CB;
    logic                     resetCore_N;
    logic                     cfgWrEn;
    logic [SEL_W-1:0]         cfgSel;
    logic [DATA_W-1:0]        cfgValue;
    logic [1:0]               cfgMode;
    logic [CNT_W-1:0]         cfgThresh;
    logic [NUM_DVC-1:0]       armEn;
    logic [NUM_DVC-1:0]       clrSticky;
    logic                     dataValid;
    logic [DATA_W-1:0]        dataIn;
    logic [BYTES-1:0]         byteEn;
    logic [NUM_DVC*BYTES-1:0] dvcByteCmp;
    logic [NUM_DVC-1:0]       dvcHit;
    logic [NUM_DVC-1:0]       dvcSticky;
    logic [NUM_DVC-1:0]       dvcEvent;
    logic [NUM_DVC*CNT_W-1:0] dvcCount;

    p405s_ld_st_dvc_unit #(
        .NUM_DVC (NUM_DVC),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .CB          (CB),
        .resetCore_N (resetCore_N),
        .cfgWrEn     (cfgWrEn),
        .cfgSel      (cfgSel),
        .cfgValue    (cfgValue),
        .cfgMode     (cfgMode),
        .cfgThresh   (cfgThresh),
        .armEn       (armEn),
        .clrSticky   (clrSticky),
        .dataValid   (dataValid),
        .dataIn      (dataIn),
        .byteEn      (byteEn),
        .dvcByteCmp  (dvcByteCmp),
        .dvcHit      (dvcHit),
        .dvcSticky   (dvcSticky),
        .dvcEvent    (dvcEvent),
        .dvcCount    (dvcCount)
    );

    initial CB = 1'b0;
    always #5 CB = ~CB;

    typedef struct {
        logic [NUM_DVC*BYTES-1:0] cmp;
        logic [NUM_DVC-1:0]       hit;
        logic [NUM_DVC-1:0]       sticky;
        logic [NUM_DVC-1:0]       evt;
        logic [NUM_DVC*CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ev0      = 0;

    // Reference model state: 0 disarmed, 1 armed, 2 fired
    logic [DATA_W-1:0] m_val    [NUM_DVC];
    logic [1:0]        m_mode   [NUM_DVC];
    int                m_thr    [NUM_DVC];
    int                m_st     [NUM_DVC];
    int                m_cnt    [NUM_DVC];
    logic              m_sticky [NUM_DVC];
    logic              m_s1_v;
    logic [DATA_W-1:0] m_s1_d;
    logic [BYTES-1:0]  m_s1_be;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_push();
        exp_t e;
        e.cmp = '0; e.hit = '0; e.sticky = '0; e.evt = '0; e.cnt = '0;
        if (!resetCore_N) begin
            for (int i = 0; i < NUM_DVC; i++) begin
                m_val[i] = '0; m_mode[i] = 2'b00; m_thr[i] = 1;
                m_st[i] = 0; m_cnt[i] = 0; m_sticky[i] = 1'b0;
            end
            m_s1_v = 1'b0; m_s1_d = '0; m_s1_be = '0;
            sb_q.push_back(e);
            return;
        end
        for (int i = 0; i < NUM_DVC; i++) begin
            logic [BYTES-1:0] eq;
            logic h;
            logic wr;
            eq = '0;
            for (int k = 0; k < BYTES; k++)
                if (m_s1_be[k] && (m_s1_d[8*k +: 8] == m_val[i][8*k +: 8])) eq[k] = 1'b1;
            h = 1'b0;
            if (m_s1_v) begin
                case (m_mode[i])
                    2'b01:   h = (eq != 0);
                    2'b10:   h = (m_s1_be != 0) && (eq == m_s1_be);
                    2'b11:   h = ((m_s1_be & ~eq) != 0);
                    default: h = 1'b0;
                endcase
            end
            e.cmp[i*BYTES +: BYTES] = m_s1_v ? eq : '0;
            e.hit[i] = h;
            m_sticky[i] = h | (m_sticky[i] & !clrSticky[i]);
            e.sticky[i] = m_sticky[i];
            wr = cfgWrEn && (int'(cfgSel) == i);
            if (wr) begin
                if (m_st[i] == 1) m_cnt[i] = 0;
                m_st[i] = 0;
            end else if (armEn[i]) begin
                m_st[i] = 1;
                m_cnt[i] = 0;
            end else if (m_st[i] == 1) begin
                if (h) begin
                    if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                    if (m_cnt[i] >= ((m_thr[i] == 0) ? 1 : m_thr[i])) begin
                        m_st[i] = 2;
                        e.evt[i] = 1'b1;
                    end
                end
            end else if (m_st[i] == 2) begin
                m_st[i] = 0;
            end
            e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
            if (wr) begin
                m_val[i] = cfgValue; m_mode[i] = cfgMode; m_thr[i] = int'(cfgThresh);
            end
        end
        m_s1_v = dataValid; m_s1_d = dataIn; m_s1_be = byteEn;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_push();
        @(posedge CB);
        #1;
        check("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("byte_cmp", 64'(dvcByteCmp), 64'(e.cmp));
            check("hit",      64'(dvcHit),     64'(e.hit));
            check("sticky",   64'(dvcSticky),  64'(e.sticky));
            check("event",    64'(dvcEvent),   64'(e.evt));
            check("count",    64'(dvcCount),   64'(e.cnt));
        end
        if (dvcEvent[0] === 1'b1) ev0++;
        cfgWrEn = 1'b0; armEn = '0; clrSticky = '0; dataValid = 1'b0;
    endtask

    task automatic cfg(input int sel, input logic [DATA_W-1:0] val, input logic [1:0] mode, input int thr);
        cfgWrEn = 1'b1; cfgSel = SEL_W'(sel); cfgValue = val; cfgMode = mode; cfgThresh = CNT_W'(thr);
        step();
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic [BYTES-1:0] be);
        dataValid = 1'b1; dataIn = d; byteEn = be;
        step();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic arm(input logic [NUM_DVC-1:0] m);
        armEn = m;
        step();
    endtask

    localparam logic [DATA_W-1:0] V = 32'h11223344;

    initial begin
        logic [DATA_W-1:0] pool [3];
        logic [DATA_W-1:0] d;
        int base;
        pool = '{32'h11223344, 32'h11FF33FF, 32'hA5A5A5A5};

        resetCore_N = 1'b0; cfgWrEn = 1'b0; cfgSel = '0; cfgValue = '0; cfgMode = 2'b00;
        cfgThresh = '0; armEn = '0; clrSticky = '0; dataValid = 1'b0; dataIn = '0; byteEn = '0;
        step();
        check("rst_count", 64'(dvcCount), 64'd0);
        step();
        resetCore_N = 1'b1;

        // Reset with hits in flight
        cfg(0, V, 2'b01, 1);
        cfg(1, 32'hA5A5A5A5, 2'b11, 2);
        cfg(2, 32'h11FF33FF, 2'b10, 1);
        arm(3'b111);
        beat(V, 4'hF);
        beat(V, 4'hF);
        resetCore_N = 1'b0; dataValid = 1'b1; dataIn = V; byteEn = 4'hF;
        step();
        check("rst_mid_hit", 64'(dvcHit), 64'd0);
        check("rst_mid_cnt", 64'(dvcCount), 64'd0);
        resetCore_N = 1'b1;
        step();
        check("rst_no_stale", 64'(dvcHit), 64'd0);

        // Byte lanes, eq-any then eq-all
        cfg(0, V, 2'b01, 1);
        beat(32'h11FF33FF, 4'hF);
        idle(1);
        check("lane_cmp", 64'(dvcByteCmp[3:0]), 64'b1010);
        check("eqany_hit", 64'(dvcHit[0]), 64'd1);
        cfg(0, V, 2'b10, 1);
        beat(32'h11FF33FF, 4'hF);
        idle(1);
        check("eqall_hit", 64'(dvcHit[0]), 64'd0);

        // Threshold of three
        cfg(0, V, 2'b01, 3);
        arm(3'b001);
        base = ev0;
        for (int j = 0; j < 4; j++) beat(V, 4'hF);
        idle(2);
        check("thr_cnt", 64'(dvcCount[7:0]), 64'd3);
        check("thr_events", 64'(ev0 - base), 64'd1);

        // Threshold 0 acts as 1, then saturation at 255
        cfg(0, V, 2'b01, 0);
        arm(3'b001);
        base = ev0;
        beat(V, 4'hF);
        idle(1);
        check("thr0_evt", 64'(dvcEvent[0]), 64'd1);
        cfg(0, V, 2'b01, 255);
        arm(3'b001);
        base = ev0;
        for (int j = 0; j < 300; j++) beat(V, 4'hF);
        idle(2);
        check("sat_cnt", 64'(dvcCount[7:0]), 64'd255);
        check("sat_events", 64'(ev0 - base), 64'd1);

        // Sticky clear colliding with a hit
        beat(V, 4'hF);
        clrSticky = 3'b001;
        step();
        check("sticky_collide", 64'(dvcSticky[0]), 64'd1);
        clrSticky = 3'b001;
        step();
        check("sticky_clr", 64'(dvcSticky[0]), 64'd0);

        // Config write to an armed comparator with a same-cycle hit
        cfg(0, V, 2'b01, 3);
        arm(3'b001);
        beat(V, 4'hF);
        beat(V, 4'hF);
        cfgWrEn = 1'b1; cfgSel = 2'd0; cfgValue = V; cfgMode = 2'b01; cfgThresh = 8'd3;
        step();
        check("cfgwr_cnt", 64'(dvcCount[7:0]), 64'd0);
        check("cfgwr_evt", 64'(dvcEvent[0]), 64'd0);
        beat(V, 4'hF);
        idle(1);
        check("cfgwr_disarmed", 64'(dvcCount[7:0]), 64'd0);

        // Arm while FIRED re-arms
        cfg(0, V, 2'b01, 1);
        arm(3'b001);
        base = ev0;
        beat(V, 4'hF);
        idle(1);
        arm(3'b001);
        beat(V, 4'hF);
        idle(1);
        check("fired_rearm_events", 64'(ev0 - base), 64'd2);

        // Empty byte enables and mode off
        cfg(0, V, 2'b11, 1);
        beat(32'hFFFFFFFF, 4'h0);
        idle(1);
        check("neany_be0", 64'(dvcHit[0]), 64'd0);
        cfg(0, V, 2'b10, 1);
        beat(V, 4'h0);
        idle(1);
        check("eqall_be0", 64'(dvcHit[0]), 64'd0);
        cfg(0, V, 2'b00, 1);
        beat(V, 4'hF);
        idle(1);
        check("off_hit", 64'(dvcHit[0]), 64'd0);
        check("off_cmp", 64'(dvcByteCmp[3:0]), 64'hF);

        // Out-of-range select is ignored
        cfg(0, V, 2'b01, 1);
        cfg(3, 32'hDEADBEEF, 2'b11, 1);
        beat(V, 4'hF);
        idle(1);
        check("sel_oob_hit", 64'(dvcHit[0]), 64'd1);

        // Randomised traffic against the model
        for (int n = 0; n < 500; n++) begin
            d = pool[$urandom_range(0, 2)];
            for (int k = 0; k < BYTES; k++)
                if ($urandom_range(0, 3) == 0) d[8*k +: 8] = 8'($urandom);
            dataValid = 1'($urandom_range(0, 1));
            dataIn    = d;
            byteEn    = 4'($urandom);
            clrSticky = ($urandom_range(0, 7) == 0) ? NUM_DVC'($urandom) : '0;
            armEn     = ($urandom_range(0, 9) == 0) ? NUM_DVC'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) begin
                cfgWrEn   = 1'b1;
                cfgSel    = SEL_W'($urandom_range(0, 3));
                cfgValue  = pool[$urandom_range(0, 2)];
                cfgMode   = 2'($urandom);
                cfgThresh = CNT_W'($urandom_range(0, 4));
                if (int'(cfgSel) < NUM_DVC) armEn[cfgSel] = 1'b0;
            end
            step();
        end
        idle(2);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
